fetch_unit: RTL

Instruction-fetch stage feeding the if_id pipeline register. It owns the PC, issues word fetches to instruction memory over a req/ack handshake, and buffers returned words with their PC+4 in a small prefetch FIFO. It also applies branch and jump redirects, flushing stale fetches. It presents one instruction per cycle to if_id, gated by the same write/stall signal.

---
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of the if_id register.
// Owns the fetch PC, keeps a single req/ack fetch to instruction memory in
// flight, and buffers returned words with their PC+4 in a small prefetch
// FIFO. Branch and jump redirects flush the FIFO. A fetch already in flight
// when a redirect arrives has its data dropped in DISCARD.
// Optional build macro FETCH_STATS_EN adds fetch_count / flush_count outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_id_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [3:0]  jump_top4,
    input  logic [25:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] inst_out,
    output logic [31:0] nxt_pc,
    output logic        inst_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    // DEPTH is restricted to 2 or 4, so pointers wrap naturally.
    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               imem_req_q, imem_req_d;
    logic [31:0]        imem_addr_q, imem_addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        inst_mem_q [DEPTH];
    logic [31:0]        pc4_mem_q  [DEPTH];

    logic               redir;
    logic [31:0]        target;
    logic               push;
    logic               pop;
    logic               has_space;
    logic [31:0]        pc_plus4;
    logic [31:0]        pc_next;

    assign redir    = branch_taken | jump;
    assign target   = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                   : {jump_top4, jump_target, 2'b00};
    assign pc_plus4 = fetch_pc_q + 32'd4;

    assign inst_valid = (count_q != '0);
    assign inst_out   = inst_valid ? inst_mem_q[rd_ptr_q] : NOP_WORD;
    assign nxt_pc     = inst_valid ? pc4_mem_q[rd_ptr_q]  : 32'h0000_0000;
    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;

    // Next-state logic: FIFO bookkeeping, fetch PC and request sequencing.
    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;

        // A redirect flushes the FIFO, so a same-cycle pop is meaningless.
        pop  = if_id_write && inst_valid && !redir;
        push = (state_q == FETCH) && imem_ack && !redir;

        if (redir) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
        end
        has_space = (count_d < DEPTH_C);

        if (redir)
            pc_next = target;
        else if (push)
            pc_next = pc_plus4;
        else
            pc_next = fetch_pc_q;
        fetch_pc_d = pc_next;

        case (state_q)
            IDLE: begin
                if (has_space) begin
                    state_d     = FETCH;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_next;
                end
            end
            FETCH, DISCARD: begin
                if (imem_ack) begin
                    // The request completes; data was pushed or dropped above.
                    if (has_space) begin
                        state_d     = FETCH;
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc_next;
                    end else begin
                        state_d     = IDLE;
                        imem_req_d  = 1'b0;
                    end
                end else if (redir) begin
                    // Keep the stale request on the bus until memory answers.
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC_ALIGNED;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'h0000_0000;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count_q so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_data;
            pc4_mem_q[wr_ptr_q]  <= pc_plus4;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;

    // Statistics next values: accepted pushes and redirect cycles, wrapping.
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(push);
        flush_count_d = flush_count_q + 16'(redir);
    end

    // Statistics counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 32'h0;
            flush_count_q <= 16'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end
`endif

endmodule
